jtdd_obj_buf: RTL

Double-buffered sprite line buffer between the object scan/draw stage and the colour mixer. While the scan stage renders line N+1 pixel by pixel into the write bank, the read bank is played out to the mixer for line N and erased behind the beam. Bank roles swap at each falling edge of HBL, the same event the scan stage uses to start a new line. Sprite priority is first-write-wins: an opaque pixel already in the buffer is never overwritten.

---
 rtl/jtdd_obj_buf.sv | 117 +++++++++++
 1 files changed

// File: rtl/jtdd_obj_buf.sv
// Double-buffered sprite line buffer: draw side fills one bank while the
// other is played out to the mixer and erased behind the beam.
module jtdd_obj_buf (
  input  logic       clk,
  input  logic       rst,
  input  logic       pxl_cen,
  input  logic       HBL,
  input  logic [7:0] HPOS,
  input  logic       flip,
  input  logic       wr_en,
  input  logic [7:0] wr_x,
  input  logic [7:0] wr_pxl,
  output logic       init_busy,
  output logic [7:0] obj_pxl
);

  logic [7:0] mem_q [0:1][0:255];

  logic       bank_q;
  logic       last_hbl_q;
  logic [7:0] clr_q;
  logic       init_q;

  logic       w0_v_q;
  logic       w0_bank_q;
  logic [7:0] w0_x_q;
  logic [7:0] w0_pxl_q;
  logic [7:0] w0_old_q;

  logic       r_v_q;
  logic       r_bank_q;
  logic [7:0] r_addr_q;
  logic [7:0] obj_q;

  logic       swap;
  logic       bank_d;
  logic       w1_we;
  logic [7:0] wr_old_d;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;

  assign swap    = ~HBL & last_hbl_q;
  assign bank_d  = bank_q ^ swap;
  assign w1_we   = w0_v_q
                 & (w0_pxl_q[3:0] != 4'd0)
                 & (w0_old_q[3:0] == 4'd0);
  assign rd_addr = flip ? ~HPOS : HPOS;
  assign rd_data = mem_q[r_bank_q][r_addr_q];

  // Same-edge writes to the W0 address must be visible to W0's lookup
  always_comb begin
    wr_old_d = mem_q[bank_d][wr_x];
    if (r_v_q && r_bank_q == bank_d && r_addr_q == wr_x)
      wr_old_d = 8'h00;
    if (w1_we && w0_bank_q == bank_d && w0_x_q == wr_x)
      wr_old_d = w0_pxl_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q     <= 1'b0;
      last_hbl_q <= 1'b0;
      clr_q      <= 8'd0;
      init_q     <= 1'b1;
      w0_v_q     <= 1'b0;
      w0_bank_q  <= 1'b0;
      w0_x_q     <= 8'd0;
      w0_pxl_q   <= 8'd0;
      w0_old_q   <= 8'd0;
      r_v_q      <= 1'b0;
      r_bank_q   <= 1'b0;
      r_addr_q   <= 8'd0;
      obj_q      <= 8'h00;
    end else begin
      last_hbl_q <= HBL;
      bank_q     <= bank_d;
      if (init_q) begin
        clr_q <= clr_q + 8'd1;
        if (clr_q == 8'hff)
          init_q <= 1'b0;
      end
      w0_v_q <= wr_en & ~init_q;
      if (wr_en) begin
        w0_bank_q <= bank_d;
        w0_x_q    <= wr_x;
        w0_pxl_q  <= wr_pxl;
        w0_old_q  <= wr_old_d;
      end
      r_v_q <= pxl_cen & ~HBL & ~init_q;
      if (pxl_cen) begin
        r_bank_q <= ~bank_d;
        r_addr_q <= rd_addr;
      end
      if (r_v_q)
        obj_q <= rd_data;
      else if (HBL)
        obj_q <= 8'h00;
    end
  end

  // W1 is issued after the erase so a swap-edge overlap keeps the sprite
  always_ff @(posedge clk) begin
    if (init_q) begin
      mem_q[0][clr_q] <= 8'h00;
      mem_q[1][clr_q] <= 8'h00;
    end else if (!rst) begin
      if (r_v_q)
        mem_q[r_bank_q][r_addr_q] <= 8'h00;
      if (w1_we)
        mem_q[w0_bank_q][w0_x_q] <= w0_pxl_q;
    end
  end

  assign init_busy = init_q;
  assign obj_pxl   = obj_q;

endmodule
